// File: rtl/mult_pkg.sv
// Shared definitions for the sequential fixed-point multiply array.
package mult_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_NUM_PROD  = 3;
  localparam int DEF_FRAC_W    = 0;
  localparam int DEF_SIGNED_EN = 1;

  // Run-control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational fixed-point multiply: full product, round half up,
// arithmetic shift by FRAC_W, saturate to the DATA_W range.
module fx_mul_sat
  import mult_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int SIGNED_EN = DEF_SIGNED_EN
) (
  input  logic [DATA_W-1:0] multiplier,
  input  logic [DATA_W-1:0] multiplicand,
  output logic [DATA_W-1:0] result,
  output logic              sat
);

  // Two guard bits above the 2*DATA_W product: one so unsigned operands
  // stay positive in a signed container, one to absorb the rounding add.
  localparam int PW  = 2 * DATA_W + 2;
  localparam bit SGN = (SIGNED_EN != 0);

  localparam logic signed [PW-1:0] ONE   = PW'(1);
  // Half an LSB of the output; collapses to zero when FRAC_W is 0.
  localparam logic signed [PW-1:0] RND_C = (ONE << FRAC_W) >>> 1;
  localparam logic signed [PW-1:0] MAX_C = SGN ? (ONE << (DATA_W - 1)) - ONE
                                               : (ONE << DATA_W) - ONE;
  localparam logic signed [PW-1:0] MIN_C = SGN ? -(ONE << (DATA_W - 1)) : '0;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rounded;
  logic signed [PW-1:0] shifted;

  // Extend, multiply, round, scale, then clamp to the output range.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    result  = '0;
    sat     = 1'b0;
    a_ext   = {{(PW - DATA_W){SGN & multiplier[DATA_W-1]}}, multiplier};
    b_ext   = {{(PW - DATA_W){SGN & multiplicand[DATA_W-1]}}, multiplicand};
    prod    = a_ext * b_ext;
    rounded = prod + RND_C;
    shifted = rounded >>> FRAC_W;
    if (shifted > MAX_C) begin
      result = MAX_C[DATA_W-1:0];
      sat    = 1'b1;
    end else if (shifted < MIN_C) begin
      result = MIN_C[DATA_W-1:0];
      sat    = 1'b1;
    end else begin
      result = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/seq_mult_array.sv
// Collects NUM_PROD processed products into output slots, one per valid
// operand pair, under an IDLE/BUSY/DONE run controller.
module seq_mult_array
  import mult_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_PROD  = DEF_NUM_PROD,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int SIGNED_EN = DEF_SIGNED_EN
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic                           i_valid,
  input  logic [DATA_W-1:0]              i_multiplier,
  input  logic [DATA_W-1:0]              i_multiplicand,
  output logic                           o_ready,
  output logic                           o_done,
  output logic                           o_ovf,
  output logic [$clog2(NUM_PROD+1)-1:0]  o_count,
  output logic [NUM_PROD*DATA_W-1:0]     o_prod
);

  localparam int              CW   = $clog2(NUM_PROD + 1);
  localparam logic [CW-1:0]   LAST = CW'(NUM_PROD - 1);

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] res;
  logic              sat;
  logic              clear;
  logic              capture;

  fx_mul_sat #(
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .SIGNED_EN(SIGNED_EN)
  ) u_fx_mul_sat (
    .multiplier  (i_multiplier),
    .multiplicand(i_multiplicand),
    .result      (res),
    .sat         (sat)
  );

  // Abort wins over a simultaneous valid, so it also suppresses capture.
  assign clear   = (state_q == IDLE) && i_start;
  assign capture = (state_q == BUSY) && i_valid && !i_abort;

  assign o_ready = (state_q == BUSY);
  assign o_done  = (state_q == DONE);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of process evaluation order.
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state decode: start in IDLE, abort or final capture in BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = BUSY;
      BUSY: begin
        if (i_abort)                          state_d = IDLE;
        else if (i_valid && (o_count == LAST)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers: cleared on an accepted start, written on capture,
  // otherwise held (including after abort and completion).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: the product slots are plain flops, not a RAM, so they take the
      // asynchronous reset like any other register.
      o_prod  <= '0;
      o_count <= '0;
      o_ovf   <= 1'b0;
    end else if (clear) begin
      o_prod  <= '0;
      o_count <= '0;
      o_ovf   <= 1'b0;
    end else if (capture) begin
      o_prod[o_count*DATA_W +: DATA_W] <= res;
      o_count                          <= o_count + CW'(1);
      if (sat) o_ovf <= 1'b1;
    end
  end

endmodule
